// File: rtl/sbox_round_sequencer.sv
// sbox_round_sequencer
// Walks one shared DES S-box through the eight 6-bit groups of a 48-bit
// key-mixed half-block. It assembles the 32-bit substitution result that
// feeds the P-permutation.
//
// Optional macro SBOX_SEQ_REG_LOOKUP_EN: when defined, the shared S-box
// output is treated as registered. Each group is then presented one cycle
// before its nibble is captured, so RUN is one cycle longer.
module sbox_round_sequencer #(
  parameter int NUM_SBOX   = 8,
  parameter int SBOX_IN_W  = 6,
  parameter int SBOX_OUT_W = 4
) (
  input  logic                              wClk,
  input  logic                              wResetN,
  input  logic                              wInValid,
  output logic                              wInReady,
  input  logic [0:NUM_SBOX*SBOX_IN_W-1]     wInputData,
  output logic                              wOutValid,
  input  logic                              wOutReady,
  output logic [0:NUM_SBOX*SBOX_OUT_W-1]    wOutputData,
  output logic                              wBusy,
  output logic                              wSboxEn,
  output logic [0:2]                        wSboxSel,
  output logic [0:SBOX_IN_W-1]              wSboxIn,
  input  logic [0:SBOX_OUT_W-1]             wSboxOut
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

`ifdef SBOX_SEQ_REG_LOOKUP_EN
  localparam int               CNT_W    = 4;
  localparam logic [CNT_W-1:0] LAST_CNT = 4'd8;
`else
  localparam int               CNT_W    = 3;
  localparam logic [CNT_W-1:0] LAST_CNT = 3'd7;
`endif

  state_t                           state;
  logic [CNT_W-1:0]                 cnt;
  logic [0:NUM_SBOX*SBOX_IN_W-1]    held;
  logic [0:NUM_SBOX*SBOX_OUT_W-1]   result;
  logic                             out_valid;
  logic                             busy;

  logic [2:0]                       present_idx;
  logic                             present_en;
  logic [2:0]                       capture_idx;
  logic                             capture_en;
  logic [0:SBOX_IN_W-1]             present_group;

  // Map the RUN cycle counter onto the group being presented and the nibble being captured
  always_comb begin
    present_idx = cnt[2:0];
    present_en  = 1'b1;
    capture_idx = cnt[2:0];
    capture_en  = 1'b1;
`ifdef SBOX_SEQ_REG_LOOKUP_EN
    present_en  = ~cnt[3];
    capture_idx = cnt[2:0] - 3'd1;
    capture_en  = (cnt != '0);
`endif
  end

  // Select the held 6-bit group that is currently presented to the shared S-box
  always_comb begin
    present_group = '0;
    for (int g = 0; g < NUM_SBOX; g++) begin
      if (present_idx == g[2:0]) begin
        present_group = held[g*SBOX_IN_W +: SBOX_IN_W];
      end
    end
  end

  // The mux request lines are driven only while this block owns the S-box; otherwise they stay at zero
  always_comb begin
    wSboxEn  = (state == RUN) && present_en;
    wSboxSel = wSboxEn ? present_idx : 3'd0;
    wSboxIn  = wSboxEn ? present_group : '0;
  end

  // In DONE, a new block may be accepted only in the same edge that the consumer takes the result
  always_comb begin
    wInReady = (state == IDLE) || ((state == DONE) && wOutReady);
  end

  assign wOutValid   = out_valid;
  assign wBusy       = busy;
  assign wOutputData = result;

  // Sequencer FSM: accept a block, step through all groups, then hold the result until it is taken
  always_ff @(posedge wClk or negedge wResetN) begin
    if (!wResetN) begin
      state     <= IDLE;
      cnt       <= '0;
      held      <= '0;
      result    <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (wInValid) begin
            held  <= wInputData;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (capture_en) begin
            for (int g = 0; g < NUM_SBOX; g++) begin
              if (capture_idx == g[2:0]) begin
                result[g*SBOX_OUT_W +: SBOX_OUT_W] <= wSboxOut;
              end
            end
          end
          if (cnt == LAST_CNT) begin
            cnt       <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (wOutReady) begin
            out_valid <= 1'b0;
            if (wInValid) begin
              held  <= wInputData;
              cnt   <= '0;
              busy  <= 1'b1;
              state <= RUN;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
